mem_arb: RTL and testbench

- Arbitrates one single-port unified memory (1-cycle read latency) among three requesters: debug loader (dbg), CPU data port (dmem), CPU fetch port (imem).
- Routes each read response back to the requester that issued it.
- Provides a halt state machine so the debug loader can freeze the CPU and load a program before release.
- Sits between the rvseed core/loader and the memory macro.

---
 rtl/mem_arb.sv | 145 ++++++++++++++
 tb/tb_mem_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Single-port memory arbiter for debug loader, CPU data and CPU fetch ports.
// Owns the CPU halt handshake and routes 1-cycle read responses to the issuer.
module mem_arb #(
    parameter int CPU_WIDTH  = 32,
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 7,
    parameter int BOOT_HALT  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dbg_halt,
    output logic                    cpu_halted,
    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [ADDR_W-1:0]       dbg_addr,
    input  logic [CPU_WIDTH-1:0]    dbg_wdata,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [CPU_WIDTH-1:0]    dbg_rdata,
    input  logic                    dmem_req,
    input  logic                    dmem_we,
    input  logic [ADDR_W-1:0]       dmem_addr,
    input  logic [CPU_WIDTH-1:0]    dmem_wdata,
    input  logic [CPU_WIDTH/8-1:0]  dmem_wstrb,
    output logic                    dmem_gnt,
    output logic                    dmem_rvalid,
    output logic [CPU_WIDTH-1:0]    dmem_rdata,
    input  logic                    imem_req,
    input  logic [ADDR_W-1:0]       imem_addr,
    output logic                    imem_gnt,
    output logic                    imem_rvalid,
    output logic [CPU_WIDTH-1:0]    imem_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [CPU_WIDTH-1:0]    mem_wdata,
    output logic [CPU_WIDTH/8-1:0]  mem_wstrb,
    input  logic [CPU_WIDTH-1:0]    mem_rdata
);
    localparam int SW = CPU_WIDTH / 8;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    typedef enum logic [1:0] {OWN_DBG, OWN_DMEM, OWN_IMEM} owner_t;

    state_t     state;
    owner_t     tag_owner;
    logic       tag_valid;
    logic [3:0] starve_cnt;
    logic       cpu_en;
    logic       starved;
    logic       rd_gnt;
    owner_t     rd_owner;

    assign cpu_en  = (state == RUN);
    assign starved = (starve_cnt >= 4'(STARVE_MAX));

    // Grants are masked by reset so nothing reaches the macro while held in reset.
    assign dbg_gnt  = rst_n && dbg_req;
    assign imem_gnt = rst_n && !dbg_req && cpu_en && imem_req && (starved || !dmem_req);
    assign dmem_gnt = rst_n && !dbg_req && cpu_en && dmem_req && !(imem_req && starved);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        rd_gnt    = 1'b0;
        rd_owner  = OWN_DBG;
        if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_wstrb = {SW{dbg_we}};
            rd_gnt    = !dbg_we;
            rd_owner  = OWN_DBG;
        end else if (dmem_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dmem_we;
            mem_addr  = dmem_addr;
            mem_wdata = dmem_wdata;
            mem_wstrb = dmem_wstrb;
            rd_gnt    = !dmem_we;
            rd_owner  = OWN_DMEM;
        end else if (imem_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = imem_addr;
            rd_gnt    = 1'b1;
            rd_owner  = OWN_IMEM;
        end
    end

    assign dbg_rvalid  = tag_valid && (tag_owner == OWN_DBG);
    assign dmem_rvalid = tag_valid && (tag_owner == OWN_DMEM);
    assign imem_rvalid = tag_valid && (tag_owner == OWN_IMEM);
    assign dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;
    assign dmem_rdata  = dmem_rvalid ? mem_rdata : '0;
    assign imem_rdata  = imem_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid  <= 1'b0;
            tag_owner  <= OWN_DBG;
            starve_cnt <= '0;
        end else begin
            tag_valid <= rd_gnt;
            tag_owner <= rd_owner;
            if (imem_req && !imem_gnt)
                starve_cnt <= (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
            else
                starve_cnt <= '0;
        end
    end

    // DRAIN waits until no CPU-side read is still in flight before freezing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= (BOOT_HALT != 0) ? HALTED : RUN;
            cpu_halted <= (BOOT_HALT != 0);
        end else begin
            case (state)
                RUN: if (dbg_halt) state <= DRAIN;
                DRAIN: begin
                    if (!dbg_halt) begin
                        state <= RUN;
                    end else if (!tag_valid || tag_owner == OWN_DBG) begin
                        state      <= HALTED;
                        cpu_halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!dbg_halt) begin
                        state      <= RUN;
                        cpu_halted <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    cpu_halted <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: vector table for arbitration/routing, plus
// starvation, halt-drain and reset-mid-read sequences.
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dbg_halt = 1'b1;
    logic        cpu_halted;
    logic        dbg_req = 0, dbg_we = 0;
    logic [11:0] dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dmem_req = 0, dmem_we = 0;
    logic [11:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        imem_req = 0;
    logic [11:0] imem_addr = '0;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;

    int ncmp = 0;
    int nerr = 0;

    mem_arb dut (
        .clk(clk), .rst_n(rst_n), .dbg_halt(dbg_halt), .cpu_halted(cpu_halted),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with 1-cycle read latency and byte strobes.
    logic [31:0] mem [4096];
    initial for (int i = 0; i < 4096; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    typedef struct packed {
        logic        halt;
        logic        dreq, dwe;
        logic [11:0] daddr;
        logic [31:0] dwd;
        logic        mreq, mwe;
        logic [11:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  mws;
        logic        ireq;
        logic [11:0] iaddr;
        logic [2:0]  gnt;   // {dbg, dmem, imem}
        logic        en, we;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [2:0]  rv;    // {dbg, dmem, imem}
        logic [31:0] rd;
        logic        hl;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dbg_halt = v.halt;
        dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
        dmem_req = v.mreq; dmem_we = v.mwe; dmem_addr = v.maddr;
        dmem_wdata = v.mwd; dmem_wstrb = v.mws;
        imem_req = v.ireq; imem_addr = v.iaddr;
    endtask

    task automatic idle(input logic halt);
        dbg_halt = halt;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        imem_req = 0; imem_addr = '0;
    endtask

    task automatic all_zero(input string tag, input logic exp_halted);
        chk({tag, ".gnt"}, {29'd0, dbg_gnt, dmem_gnt, imem_gnt}, 32'd0);
        chk({tag, ".rvalid"}, {29'd0, dbg_rvalid, dmem_rvalid, imem_rvalid}, 32'd0);
        chk({tag, ".rdata"}, dbg_rdata | dmem_rdata | imem_rdata, 32'd0);
        chk({tag, ".mem"}, {14'd0, mem_en, mem_we, mem_addr, mem_wstrb}, 32'd0);
        chk({tag, ".wdata"}, mem_wdata, 32'd0);
        chk({tag, ".halted"}, {31'd0, cpu_halted}, {31'd0, exp_halted});
    endtask

    initial begin
        //          halt dreq dwe daddr dwd          mreq mwe maddr mwd          mws   ireq iaddr  gnt    en we addr wd           ws    rv     rd           hl
        vt[0]  = '{1'b1,1'b1,1'b1,12'd0,32'h13,       1'b0,1'b0,12'd0,32'h0,       4'h0,1'b1,12'd0, 3'b100,1'b1,1'b1,12'd0,32'h13,       4'hF,3'b000,32'h0,       1'b1};
        vt[1]  = '{1'b1,1'b1,1'b1,12'd1,32'h13,       1'b0,1'b0,12'd0,32'h0,       4'h0,1'b1,12'd0, 3'b100,1'b1,1'b1,12'd1,32'h13,       4'hF,3'b000,32'h0,       1'b1};
        vt[2]  = '{1'b1,1'b1,1'b1,12'd2,32'h13,       1'b0,1'b0,12'd0,32'h0,       4'h0,1'b1,12'd0, 3'b100,1'b1,1'b1,12'd2,32'h13,       4'hF,3'b000,32'h0,       1'b1};
        vt[3]  = '{1'b1,1'b1,1'b1,12'd3,32'h13,       1'b0,1'b0,12'd0,32'h0,       4'h0,1'b1,12'd0, 3'b100,1'b1,1'b1,12'd3,32'h13,       4'hF,3'b000,32'h0,       1'b1};
        vt[4]  = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b0,1'b0,12'd0,32'h0,       4'h0,1'b1,12'd0, 3'b000,1'b0,1'b0,12'd0,32'h0,        4'h0,3'b000,32'h0,       1'b1};
        vt[5]  = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b0,1'b0,12'd0,32'h0,       4'h0,1'b1,12'd0, 3'b001,1'b1,1'b0,12'd0,32'h0,        4'h0,3'b000,32'h0,       1'b0};
        vt[6]  = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b0,1'b0,12'd0,32'h0,       4'h0,1'b0,12'd0, 3'b000,1'b0,1'b0,12'd0,32'h0,        4'h0,3'b001,32'h13,      1'b0};
        vt[7]  = '{1'b0,1'b1,1'b1,12'd5,32'hA5A5A5A5, 1'b1,1'b0,12'd5,32'h0,       4'h0,1'b1,12'd6, 3'b100,1'b1,1'b1,12'd5,32'hA5A5A5A5, 4'hF,3'b000,32'h0,       1'b0};
        vt[8]  = '{1'b0,1'b1,1'b1,12'd6,32'h5A5A5A5A, 1'b1,1'b0,12'd5,32'h0,       4'h0,1'b1,12'd6, 3'b100,1'b1,1'b1,12'd6,32'h5A5A5A5A, 4'hF,3'b000,32'h0,       1'b0};
        vt[9]  = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b1,1'b0,12'd5,32'h0,       4'h0,1'b0,12'd0, 3'b010,1'b1,1'b0,12'd5,32'h0,        4'h0,3'b000,32'h0,       1'b0};
        vt[10] = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b0,1'b0,12'd0,32'h0,       4'h0,1'b1,12'd6, 3'b001,1'b1,1'b0,12'd6,32'h0,        4'h0,3'b010,32'hA5A5A5A5,1'b0};
        vt[11] = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b0,1'b0,12'd0,32'h0,       4'h0,1'b0,12'd0, 3'b000,1'b0,1'b0,12'd0,32'h0,        4'h0,3'b001,32'h5A5A5A5A,1'b0};
        vt[12] = '{1'b0,1'b1,1'b0,12'd5,32'h0,        1'b0,1'b0,12'd0,32'h0,       4'h0,1'b0,12'd0, 3'b100,1'b1,1'b0,12'd5,32'h0,        4'h0,3'b000,32'h0,       1'b0};
        vt[13] = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b1,1'b1,12'd7,32'h12345678,4'h3,1'b0,12'd0, 3'b010,1'b1,1'b1,12'd7,32'h12345678,4'h3,3'b100,32'hA5A5A5A5,1'b0};
        vt[14] = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b1,1'b0,12'd7,32'h0,       4'h0,1'b0,12'd0, 3'b010,1'b1,1'b0,12'd7,32'h0,        4'h0,3'b000,32'h0,       1'b0};
        vt[15] = '{1'b0,1'b0,1'b0,12'd0,32'h0,        1'b0,1'b0,12'd0,32'h0,       4'h0,1'b0,12'd0, 3'b000,1'b0,1'b0,12'd0,32'h0,        4'h0,3'b010,32'h00005678,1'b0};

        // Reset state
        idle(1'b1);
        dbg_req = 1'b1;
        #12;
        all_zero("reset", 1'b1);
        @(negedge clk);
        idle(1'b1);
        rst_n = 1'b1;
        #1 all_zero("post_reset", 1'b1);

        // Vector table: boot load, release, priority, alternating reads, strobes
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d.gnt", i), {29'd0, dbg_gnt, dmem_gnt, imem_gnt}, {29'd0, vt[i].gnt});
            chk($sformatf("v%0d.mem", i), {14'd0, mem_en, mem_we, mem_addr, mem_wstrb},
                {14'd0, vt[i].en, vt[i].we, vt[i].addr, vt[i].ws});
            chk($sformatf("v%0d.wdata", i), mem_wdata, vt[i].wd);
            chk($sformatf("v%0d.rvalid", i), {29'd0, dbg_rvalid, dmem_rvalid, imem_rvalid}, {29'd0, vt[i].rv});
            chk($sformatf("v%0d.dbg_rdata", i), dbg_rdata, vt[i].rv[2] ? vt[i].rd : 32'h0);
            chk($sformatf("v%0d.dmem_rdata", i), dmem_rdata, vt[i].rv[1] ? vt[i].rd : 32'h0);
            chk($sformatf("v%0d.imem_rdata", i), imem_rdata, vt[i].rv[0] ? vt[i].rd : 32'h0);
            chk($sformatf("v%0d.halted", i), {31'd0, cpu_halted}, {31'd0, vt[i].hl});
        end

        // Starvation: dmem wins 7 cycles, imem the 8th, repeating
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            idle(1'b0);
            dmem_req = 1'b1; dmem_addr = 12'd1;
            imem_req = 1'b1; imem_addr = 12'd2;
            #1;
            chk($sformatf("starve%0d.dmem_gnt", k), {31'd0, dmem_gnt}, {31'd0, (k % 8) != 7});
            chk($sformatf("starve%0d.imem_gnt", k), {31'd0, imem_gnt}, {31'd0, (k % 8) == 7});
        end
        @(negedge clk);
        idle(1'b0);
        @(negedge clk);

        // Halt while a dmem read is granted: drain the response, then freeze
        idle(1'b1);
        dmem_req = 1'b1; dmem_addr = 12'd5;
        #1 chk("drain0.dmem_gnt", {31'd0, dmem_gnt}, 32'd1);
        @(negedge clk);
        imem_req = 1'b1; imem_addr = 12'd6;
        #1;
        chk("drain1.gnt", {30'd0, dmem_gnt, imem_gnt}, 32'd0);
        chk("drain1.dmem_rvalid", {31'd0, dmem_rvalid}, 32'd1);
        chk("drain1.dmem_rdata", dmem_rdata, 32'hA5A5A5A5);
        chk("drain1.halted", {31'd0, cpu_halted}, 32'd0);
        @(negedge clk);
        #1;
        chk("drain2.gnt", {30'd0, dmem_gnt, imem_gnt}, 32'd0);
        chk("drain2.rvalid", {31'd0, dmem_rvalid}, 32'd0);
        chk("drain2.halted", {31'd0, cpu_halted}, 32'd0);
        @(negedge clk);
        #1;
        chk("drain3.gnt", {30'd0, dmem_gnt, imem_gnt}, 32'd0);
        chk("drain3.halted", {31'd0, cpu_halted}, 32'd1);
        idle(1'b0);
        @(negedge clk);
        #1 chk("release.halted", {31'd0, cpu_halted}, 32'd0);

        // Reset the cycle after a granted imem read: response must be dropped
        @(negedge clk);
        idle(1'b0);
        imem_req = 1'b1; imem_addr = 12'd6;
        #1 chk("rst_rd.imem_gnt", {31'd0, imem_gnt}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        dbg_req = 1'b1;
        #1 all_zero("in_reset", 1'b1);
        @(negedge clk);
        #1 all_zero("in_reset2", 1'b1);
        @(negedge clk);
        idle(1'b1);
        rst_n = 1'b1;
        #1 all_zero("after_reset", 1'b1);
        @(negedge clk);
        #1 all_zero("after_reset2", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
